mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch port (F stage) and the data port (M stage) of the pipelined MIPS core.
- Sits between the core and the memory model. Per-port request/valid handshakes let the hazard logic stall F/D or M while an access is pending.
- Data accesses have priority. A bounded-burst fairness counter guarantees that fetch is not starved.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch port and the data port.
// Data wins ties; after MAX_DBURST data grants with a fetch waiting, the fetch is served next.
module mem_arbiter #(
  parameter int MAX_DBURST = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          ivalid,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dvalid,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready,
  output logic          busy
);

  // Handshake: a requester holds req and its address/data stable until its valid pulse;
  // the memory side sees mreq held with stable maddr/mwe/mwdata until mready.
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DBURST);

  state_t     state, nextState;
  logic [3:0] dcount, nextDcount;
  logic       grantData, grantFetch;
  logic       ownerData;

  always_comb begin
    nextState  = state;
    nextDcount = dcount;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && !(ireq && dcount == MAXD)) begin
          grantData = 1'b1;
          nextState = BUSY_D;
          if (ireq) nextDcount = (dcount == MAXD) ? MAXD : dcount + 4'd1;
          else      nextDcount = 4'd0;
        end else if (ireq) begin
          grantFetch = 1'b1;
          nextState  = BUSY_I;
          nextDcount = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mready) nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dcount    <= 4'd0;
      ownerData <= 1'b0;
      maddr     <= '0;
      mwe       <= 1'b0;
      mwdata    <= '0;
      irdata    <= '0;
      drdata    <= '0;
    end else begin
      state  <= nextState;
      dcount <= nextDcount;
      if (grantData) begin
        ownerData <= 1'b1;
        maddr     <= daddr;
        mwe       <= dwe;
        mwdata    <= dwdata;
      end else if (grantFetch) begin
        ownerData <= 1'b0;
        maddr     <= iaddr;
        mwe       <= 1'b0;
      end
      if (state == BUSY_I && mready) irdata <= mrdata;
      // Stores return nothing, so drdata keeps the last load result.
      if (state == BUSY_D && mready && !mwe) drdata <= mrdata;
    end
  end

  assign mreq   = (state == BUSY_I) || (state == BUSY_D);
  assign ivalid = (state == RESP) && !ownerData;
  assign dvalid = (state == RESP) && ownerData;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus collision,
// fairness, spurious-mready and mid-access reset sequences against a latency-configurable memory.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq, dreq, dwe;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] irdata, drdata;
  logic          ivalid, dvalid;
  logic          mreq, mwe, mready, busy;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata, mrdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DBURST(MAXD), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dvalid(dvalid),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata), .mready(mready),
    .busy(busy)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: answers after memLat cycles of mreq; spurious forces mready outside accesses.
  logic [DW-1:0] mem [0:63];
  int   memLat   = 1;
  int   waitCnt  = 0;
  logic spurious = 1'b0;

  initial begin
    mready = 1'b0;
    mrdata = '0;
    forever begin
      @(negedge clk);
      if (mreq) begin
        waitCnt++;
        if (waitCnt >= memLat) begin
          mready = 1'b1;
          mrdata = mem[maddr[7:2]];
          if (mwe) mem[maddr[7:2]] = mwdata;
          waitCnt = 0;
        end else begin
          mready = 1'b0;
        end
      end else begin
        waitCnt = 0;
        mready  = spurious;
        mrdata  = spurious ? 32'hBAD0BAD0 : 32'h0;
      end
    end
  end

  int protoViol = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (ivalid && dvalid)            protoViol++;
      if (mreq && !busy)               protoViol++;
      if (mreq && (ivalid || dvalid))  protoViol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          isData;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] expRdata;
  } vec_t;

  logic [DW-1:0] expIrdata  = '0;
  logic [DW-1:0] expDrdata  = '0;
  logic [DW-1:0] lastMwdata = '0;

  // One access from an idle arbiter; called and returning on a negedge.
  task automatic runVec(input vec_t v, input string tag);
    int            cyc;
    logic          gotValid, busBad;
    logic [DW-1:0] expMw;
    memLat = v.lat;
    expMw  = v.isData ? v.wdata : lastMwdata;
    if (v.isData) begin
      dreq = 1'b1; dwe = v.we; daddr = v.addr; dwdata = v.wdata;
    end else begin
      ireq = 1'b1; iaddr = v.addr;
    end
    cyc = 0; gotValid = 1'b0; busBad = 1'b0;
    while (!gotValid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mreq && (maddr !== v.addr || mwe !== (v.isData && v.we) || mwdata !== expMw)) busBad = 1'b1;
      if (v.isData ? dvalid : ivalid) gotValid = 1'b1;
    end
    ireq = 1'b0;
    dreq = 1'b0;
    if (v.isData && !v.we) expDrdata = v.expRdata;
    if (!v.isData)         expIrdata = v.expRdata;
    lastMwdata = expMw;
    check({tag, " valid"}, DW'(gotValid), 32'd1);
    check({tag, " latency"}, DW'(cyc), DW'(v.lat + 1));
    check({tag, " bus stable"}, DW'(busBad), 32'd0);
    check({tag, " irdata"}, irdata, expIrdata);
    check({tag, " drdata"}, drdata, expDrdata);
    @(negedge clk);
    check({tag, " one pulse"}, DW'({ivalid, dvalid, busy}), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    int   cyc, gap, ev;
    logic bad;
    logic [AW-1:0] firstMaddr;
    logic gotKind [10];
    logic expKind [10];

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[16] = 32'h20020005;  // 0x40
    mem[17] = 32'h8C430000;  // 0x44
    mem[22] = 32'h12345678;  // 0x58

    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        2,  32'h20020005};
    vecs[1] = '{1'b1, 1'b1, 32'h54, 32'hDEADBEEF, 1,  32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h54, 32'h11111111, 1,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,        3,  32'h8C430000};
    vecs[4] = '{1'b1, 1'b0, 32'h58, 32'h33333333, 10, 32'h12345678};
    vecs[5] = '{1'b1, 1'b1, 32'h58, 32'hA5A5A5A5, 2,  32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h58, 32'h44444444, 1,  32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b0, 32'h40, 32'h0,        1,  32'h20020005};

    expKind = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0;
    repeat (3) @(negedge clk);
    check("reset ctrl", DW'({mreq, mwe, ivalid, dvalid, busy}), 32'd0);
    check("reset maddr", maddr, 32'h0);
    check("reset mwdata", mwdata, 32'h0);
    check("reset irdata", irdata, 32'h0);
    check("reset drdata", drdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // Collision: both requests in the same cycle, data goes first.
    memLat = 2;
    ireq = 1'b1; iaddr = 32'h44;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h54; dwdata = 32'h22222222;
    cyc = 0; firstMaddr = '1;
    while (!dvalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mreq && firstMaddr === '1) firstMaddr = maddr;
    end
    dreq = 1'b0;
    lastMwdata = 32'h22222222;
    check("collision first grant", firstMaddr, 32'h54);
    check("collision drdata", drdata, 32'hDEADBEEF);
    gap = 0;
    while (!mreq && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    check("collision fetch gap", DW'(gap), 32'd2);
    check("collision fetch maddr", maddr, 32'h44);
    cyc = 0;
    while (!ivalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    ireq = 1'b0;
    check("collision irdata", irdata, 32'h8C430000);
    @(negedge clk);

    // Fairness: both held; four data grants, then one fetch, repeating.
    memLat = 1;
    ireq = 1'b1; iaddr = 32'h40;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h60; dwdata = 32'h0;
    ev = 0; cyc = 0;
    while (ev < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (dvalid) begin
        gotKind[ev] = 1'b1; ev++; daddr = daddr + 32'd4;
      end else if (ivalid) begin
        gotKind[ev] = 1'b0; ev++;
      end
    end
    ireq = 1'b0; dreq = 1'b0;
    lastMwdata = 32'h0;
    check("fairness events", DW'(ev), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("fairness event%0d", i), DW'(gotKind[i]), DW'(expKind[i]));
    @(negedge clk);

    // Spurious mready while idle must be ignored.
    spurious = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ivalid || dvalid || busy || mreq) bad = 1'b1;
    end
    spurious = 1'b0;
    @(negedge clk);
    check("spurious mready ignored", DW'(bad), 32'd0);
    check("spurious irdata held", irdata, expIrdata);

    // Reset during BUSY_D before mready.
    memLat = 50;
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h54; dwdata = 32'h99999999;
    cyc = 0;
    while (!mreq && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    reset = 1'b1; dreq = 1'b0;
    @(negedge clk);
    check("midreset outputs", DW'({mreq, busy, dvalid, ivalid}), 32'd0);
    reset = 1'b0;
    expIrdata = '0; expDrdata = '0; lastMwdata = '0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dvalid || ivalid || mreq) bad = 1'b1;
    end
    check("midreset no pulse", DW'(bad), 32'd0);
    runVec('{1'b0, 1'b0, 32'h40, 32'h0, 2, 32'h20020005}, "postreset");

    check("protocol violations", DW'(protoViol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
